sprite_motion_ctrl: RTL
=======================

Name: sprite_motion_ctrl

Overview:
Parametrised movement controller for a player or enemy sprite on the VGA playfield. It turns held direction buttons into a pixel-stepped sprite position, using a programmable step rate and step size, wall clamping, per-direction collision blocking, freeze and respawn. It also outputs facing, moving state and a walk-animation frame. It sits between the button debouncers / collision comparator and the sprite ROM, and produces the sprite window hit and local row/column for the current VGA pixel.

Parameters:
CW, 10, width of all pixel coordinates
X_MIN, 144, left edge of playfield (pixel)
X_MAX, 740, right edge of playfield (exclusive)
Y_MIN, 144, top edge of playfield
Y_MAX, 500, bottom edge of playfield (exclusive)
SPR_W, 16, sprite width in pixels
SPR_H, 16, sprite height in pixels
START_X, 144, spawn x; must lie in [X_MIN, X_MAX-SPR_W]
START_Y, 400, spawn y; must lie in [Y_MIN, Y_MAX-SPR_H]
TICK_DIV, 100000, clocks per movement tick; must be >= 2
STEP, 1, pixels moved per tick; must be >= 1
FRAME_STEPS, 8, successful steps per animation frame advance; must be >= 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
respawn  in  1  synchronous return to spawn point
btn_l, btn_r, btn_u, btn_d  in  1 each  held direction requests
blocked  in  4  collision flags: [0]=L, [1]=R, [2]=U, [3]=D
freeze  in  1  game over / pause; suppresses position change
v_x, v_y  in  CW each  current VGA pixel
pos_x, pos_y  out  CW each  sprite top-left corner (registered)
dir  out  2  facing: 0=L, 1=R, 2=U, 3=D (registered)
moving  out  1  1 when FSM is in any MOVE state
anim_frame  out  2  walk frame 0..3 (registered)
sprite_on  out  1  v_x/v_y lies inside the sprite window
spr_col, spr_row  out  CW each  pixel offset inside the sprite; 0 when sprite_on=0

Behaviour:
- Reset (async): pos=(START_X, START_Y), state=IDLE, tick counter=0, dir=3, anim_frame=0, step counter=0.
- respawn=1 at a clock edge: same values as reset. Overrides every other input.
- States: IDLE, MOVE_L, MOVE_R, MOVE_U, MOVE_D.
- IDLE: tick counter held at 0. Next state follows priority L>R>U>D among pressed buttons. dir is set to the chosen direction on the same edge. With no button pressed, stay IDLE. anim_frame and the step counter clear to 0 in IDLE.
- MOVE_x with its own button low: go to IDLE next edge, clear counter, no step. Other buttons are ignored in MOVE_x, so a direction change always passes through one IDLE cycle.
- MOVE_x with button held: the counter increments. When counter==TICK_DIV-1 a tick occurs and the counter goes to 0. The first tick therefore lands TICK_DIV clocks after entry, then every TICK_DIV clocks.
- On a tick, a step happens only if the matching blocked bit is 0, freeze=0 and the sprite is not already at the wall.
- Step arithmetic is clamped and never overshoots:
  - L: pos_x = max(pos_x-STEP, X_MIN)
  - R: pos_x = min(pos_x+STEP, X_MAX-SPR_W)
  - U: pos_y = max(pos_y-STEP, Y_MIN)
  - D: pos_y = min(pos_y+STEP, Y_MAX-SPR_H)
- Compute step arithmetic in CW+1 bits so there is no wrap-around.
- A tick that is blocked, frozen or at the wall changes no position, but the counter still wraps.
- Animation: each successful step increments the step counter. When it reaches FRAME_STEPS it clears and anim_frame increments, wrapping 3->0. Non-step ticks do not advance it.
- freeze and blocked are sampled only on tick cycles; between ticks they have no effect.
- sprite_on = (v_x >= pos_x) && (v_x < pos_x+SPR_W) && (v_y >= pos_y) && (v_y < pos_y+SPR_H). Combinational.
- spr_col = v_x-pos_x and spr_row = v_y-pos_y when sprite_on=1, otherwise 0. Combinational.
- moving = (state != IDLE). Combinational from the state register.

Test Plan:
1. Reset, then btn_r held 13 clocks, with TICK_DIV=4 and STEP=1 -> entry 1 clock, then ticks at clocks 5, 9, 13; pos_x 144->147; dir=1; moving=1.
2. X_MAX=200, STEP=3, START_X=181, btn_r held -> pos_x goes 181->184 and clamps at 184, with no further change on later ticks.
3. btn_l held, blocked[0]=1 at the tick -> pos_x unchanged and counter wraps. blocked[0]=0 at the next tick -> pos_x-1.
4. btn_u held with freeze=1 for 3 ticks -> pos_y constant and anim_frame constant. freeze dropped -> steps resume. Respawn mid-move -> pos=(144,400), dir=3, moving=0 next edge.
5. FRAME_STEPS=2, btn_d held 9 steps -> anim_frame sequence 0,0,1,1,2,2,3,3,0. Release -> anim_frame=0 in IDLE.
6. pos=(200,300): v=(199,300) -> sprite_on=0, col=0. v=(200,300) -> on, col=0. v=(215,315) -> on, col=15, row=15. v=(216,300) -> off. Assert reset mid-tick -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// Sprite movement controller: held buttons become tick-paced, wall-clamped pixel steps.
// Also reports facing, walk animation frame and the sprite window for the current VGA pixel.
module sprite_motion_ctrl #(
  parameter int unsigned CW          = 10,
  parameter int unsigned X_MIN       = 144,
  parameter int unsigned X_MAX       = 740,
  parameter int unsigned Y_MIN       = 144,
  parameter int unsigned Y_MAX       = 500,
  parameter int unsigned SPR_W       = 16,
  parameter int unsigned SPR_H       = 16,
  parameter int unsigned START_X     = 144,
  parameter int unsigned START_Y     = 400,
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned STEP        = 1,
  parameter int unsigned FRAME_STEPS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          respawn,
  input  logic          btn_l,
  input  logic          btn_r,
  input  logic          btn_u,
  input  logic          btn_d,
  input  logic [3:0]    blocked,
  input  logic          freeze,
  input  logic [CW-1:0] v_x,
  input  logic [CW-1:0] v_y,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic [1:0]    dir,
  output logic          moving,
  output logic [1:0]    anim_frame,
  output logic          sprite_on,
  output logic [CW-1:0] spr_col,
  output logic [CW-1:0] spr_row
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(FRAME_STEPS + 1);

  localparam logic [CW:0] XLo   = (CW+1)'(X_MIN);
  localparam logic [CW:0] XHi   = (CW+1)'(X_MAX - SPR_W);
  localparam logic [CW:0] YLo   = (CW+1)'(Y_MIN);
  localparam logic [CW:0] YHi   = (CW+1)'(Y_MAX - SPR_H);
  localparam logic [CW:0] StepE = (CW+1)'(STEP);
  localparam logic [CW:0] SprW  = (CW+1)'(SPR_W);
  localparam logic [CW:0] SprH  = (CW+1)'(SPR_H);

  typedef enum logic [2:0] {StIdle, StMoveL, StMoveR, StMoveU, StMoveD} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [1:0]      dir_q, dir_d, anim_q, anim_d;
  logic [SW-1:0]   steps_q, steps_d;

  logic            held, tick, at_wall, do_step;
  logic [CW:0]     x_e, y_e, vx_e, vy_e;

  // State register plus registered datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pos_x_q <= CW'(START_X);
      pos_y_q <= CW'(START_Y);
      dir_q   <= 2'd3;
      anim_q  <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q   <= dir_d;
      anim_q  <= anim_d;
      steps_q <= steps_d;
    end
  end

  // Next-state logic: a move state only ever exits to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if      (btn_l) state_d = StMoveL;
        else if (btn_r) state_d = StMoveR;
        else if (btn_u) state_d = StMoveU;
        else if (btn_d) state_d = StMoveD;
      end
      StMoveL: if (!btn_l) state_d = StIdle;
      StMoveR: if (!btn_r) state_d = StIdle;
      StMoveU: if (!btn_u) state_d = StIdle;
      StMoveD: if (!btn_d) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (respawn) state_d = StIdle;
  end

  assign x_e = {1'b0, pos_x_q};
  assign y_e = {1'b0, pos_y_q};

  // In a move state dir_q always equals the move direction, so it selects the axis.
  always_comb begin
    held = ((state_q == StMoveL) && btn_l) || ((state_q == StMoveR) && btn_r) ||
           ((state_q == StMoveU) && btn_u) || ((state_q == StMoveD) && btn_d);
    tick = held && (cnt_q == TW'(TICK_DIV - 1));
    unique case (dir_q)
      2'd0:    at_wall = (x_e <= XLo);
      2'd1:    at_wall = (x_e >= XHi);
      2'd2:    at_wall = (y_e <= YLo);
      default: at_wall = (y_e >= YHi);
    endcase
    do_step = tick && !blocked[dir_q] && !freeze && !at_wall;

    cnt_d   = '0;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    anim_d  = anim_q;
    steps_d = steps_q;

    if (held && !tick) cnt_d = cnt_q + 1'b1;

    if (state_q == StIdle) begin
      anim_d  = '0;
      steps_d = '0;
      if      (btn_l) dir_d = 2'd0;
      else if (btn_r) dir_d = 2'd1;
      else if (btn_u) dir_d = 2'd2;
      else if (btn_d) dir_d = 2'd3;
    end else if (do_step) begin
      unique case (dir_q)
        2'd0:    pos_x_d = (x_e < XLo + StepE) ? CW'(XLo) : CW'(x_e - StepE);
        2'd1:    pos_x_d = (x_e + StepE > XHi) ? CW'(XHi) : CW'(x_e + StepE);
        2'd2:    pos_y_d = (y_e < YLo + StepE) ? CW'(YLo) : CW'(y_e - StepE);
        default: pos_y_d = (y_e + StepE > YHi) ? CW'(YHi) : CW'(y_e + StepE);
      endcase
      if (steps_q == SW'(FRAME_STEPS - 1)) begin
        steps_d = '0;
        anim_d  = anim_q + 2'd1;
      end else begin
        steps_d = steps_q + 1'b1;
      end
    end

    if (respawn) begin
      cnt_d   = '0;
      pos_x_d = CW'(START_X);
      pos_y_d = CW'(START_Y);
      dir_d   = 2'd3;
      anim_d  = '0;
      steps_d = '0;
    end
  end

  assign vx_e = {1'b0, v_x};
  assign vy_e = {1'b0, v_y};

  // Outputs: moving from the state register, sprite window from the current pixel.
  always_comb begin
    moving     = (state_q != StIdle);
    pos_x      = pos_x_q;
    pos_y      = pos_y_q;
    dir        = dir_q;
    anim_frame = anim_q;
    sprite_on  = (vx_e >= x_e) && (vx_e < x_e + SprW) && (vy_e >= y_e) && (vy_e < y_e + SprH);
    spr_col    = sprite_on ? (v_x - pos_x_q) : '0;
    spr_row    = sprite_on ? (v_y - pos_y_q) : '0;
  end

endmodule
